decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 The block SHALL have parameter SEL_W, default 3, giving the select width; the output width is NOUT = 2**SEL_W; legal range is 1..6.
REQ-002 The block SHALL have parameter DWELL, default 4, giving cycles per scan position; legal range is 1..65535.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
en  in  1  block enable
mode  in  1  0 = direct decode, 1 = auto-scan
sel  in  SEL_W  select code
sel_valid  in  1  sel offered
sel_ready  out  1  sel accepted when high with sel_valid
y  out  NOUT  registered one-hot output, bit k = code k
idx  out  SEL_W  code currently driven on y
wrap  out  1  one-cycle pulse on scan wrap-around

Function
REQ-005 The FSM SHALL have states IDLE (y all-zero), HOLD (y = onehot(idx)) and SCAN (stepping).
REQ-006 sel_ready SHALL be combinational: en AND NOT mode.
REQ-007 A handshake (sel_valid AND sel_ready) SHALL load idx <= sel and y <= onehot(sel) at that clock edge, with state -> HOLD; latency is 1 cycle.
REQ-008 In HOLD without a handshake, y and idx SHALL hold their values.
REQ-009 en=0 SHALL force state -> IDLE and y <= 0 at the next edge, retain idx, and take priority over all other inputs.
REQ-010 When en=1 and mode=1 in IDLE or HOLD, the block SHALL move to SCAN with idx <= 0, y <= onehot(0) and dwell count <= 0.
REQ-011 In SCAN, the dwell count SHALL increment each cycle; at DWELL-1 it clears and idx increments, with y following onehot(idx) in the same edge.
REQ-012 idx SHALL wrap from NOUT-1 to 0, and wrap SHALL be high during the cycle in which y = onehot(0) after a wrap; wrap SHALL not be asserted on initial SCAN entry.
REQ-013 When DWELL=1, idx SHALL advance every cycle.
REQ-014 mode=0 in SCAN SHALL give state -> IDLE and y <= 0, unless a handshake occurs in the same cycle, in which case REQ-007 applies.
REQ-015 y SHALL never have more than one bit set.

Reset
REQ-016 When rst_n=0 at an edge: state = IDLE, y = 0, idx = 0, wrap = 0, dwell count = 0; sel_ready still follows REQ-006.
REQ-017 Reset asserted mid-scan SHALL abort immediately, with no wrap pulse.

Configuration
REQ-018 With DEC_SCAN_EN defined, the SCAN state, dwell counter and wrap logic SHALL be present.
REQ-019 Without DEC_SCAN_EN, mode SHALL be ignored (treated as 0), wrap SHALL be tied to 0, DWELL SHALL be unused, and no SCAN state SHALL exist.

Structure
REQ-020 Package dec_pkg SHALL hold the state enum (IDLE, HOLD, SCAN) and the function onehot(code, width).
REQ-021 The dwell counter SHALL be sub-module dec_dwell_cnt (parameter DWELL; ports clk, rst_n, clr, tick) and SHALL be instantiated only under DEC_SCAN_EN.

Verification
REQ-022 Reset, then en=1, mode=0, sel=5, sel_valid=1 for one cycle -> next cycle y=8'b0010_0000, idx=5; held until the next handshake.
REQ-023 In HOLD idx=5, drop en to 0 -> next cycle y=0, idx=5, sel_ready=0.
REQ-024 DWELL=4, mode=1 -> y steps 0x01, 0x02, ... 0x80, each for 4 cycles; wrap pulses once when y returns to 0x01 (cycle 32 after entry).
REQ-025 In SCAN at idx=3, set mode=0 with sel=6 and sel_valid=1 -> next cycle state HOLD, y=0x40; with sel_valid=0 -> y=0.
REQ-026 Pull rst_n low during SCAN at idx=7, dwell count 3 -> next cycle y=0, idx=0, wrap=0.
REQ-027 Build without DEC_SCAN_EN, drive mode=1 with a handshake of sel=2 -> y=0x04 and wrap stays 0 throughout.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared types and helpers for the select decoder / scanner.
package dec_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      SCAN = 2'd2
   } state_t;

   // One-hot of code, clipped to width bits (codes >= width give zero).
   function automatic logic [63:0] onehot(input logic [5:0] code, input int width);
      onehot = '0;
      if (int'(code) < width) onehot[code] = 1'b1;
   endfunction

endpackage

// File: rtl/dec_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 and flags the last cycle of each dwell period.
module dec_dwell_cnt #(
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(DWELL - 1));

   always_ff @(posedge clk) begin
      if (!rst_n || clr) cnt <= '0;
      else if (tick)     cnt <= '0;
      else               cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with handshake load and optional auto-scan.
// Auto-scan (SCAN state, dwell counter, wrap pulse) exists only when DEC_SCAN_EN is defined.
module decoder_scan
   import dec_pkg::*;
#(
   parameter int SEL_W = 3,
   parameter int DWELL = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  sel_valid,
   output logic                  sel_ready,
   output logic [2**SEL_W-1:0]   y,
   output logic [SEL_W-1:0]      idx,
   output logic                  wrap
);

   localparam int NOUT = 2**SEL_W;

   state_t state;
   logic   hs;

`ifdef DEC_SCAN_EN
   logic             tick;
   logic [SEL_W-1:0] idx_nx;

   assign sel_ready = en & ~mode;
   assign idx_nx    = idx + 1'b1;

   // Counter is held clear outside SCAN so every scan entry starts at dwell 0.
   dec_dwell_cnt #(.DWELL(DWELL)) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state != SCAN),
      .tick  (tick)
   );
`else
   logic        mode_unused;
   logic [31:0] dwell_unused;

   assign sel_ready    = en;
   assign wrap         = 1'b0;
   assign mode_unused  = mode;
   assign dwell_unused = 32'(DWELL);
`endif

   assign hs = sel_valid & sel_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         y     <= '0;
         idx   <= '0;
`ifdef DEC_SCAN_EN
         wrap  <= 1'b0;
`endif
      end else begin
`ifdef DEC_SCAN_EN
         wrap <= 1'b0;
`endif
         if (!en) begin
            state <= IDLE;
            y     <= '0;
         end else if (hs) begin
            state <= HOLD;
            idx   <= sel;
            y     <= NOUT'(onehot(6'(sel), NOUT));
         end
`ifdef DEC_SCAN_EN
         else if (mode && state != SCAN) begin
            state <= SCAN;
            idx   <= '0;
            y     <= NOUT'(1);
         end else if (state == SCAN) begin
            if (!mode) begin
               state <= IDLE;
               y     <= '0;
            end else if (tick) begin
               idx  <= idx_nx;
               y    <= NOUT'(onehot(6'(idx_nx), NOUT));
               wrap <= &idx;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: two instances (DWELL=4 and DWELL=1) against a cycle-count model.
module tb_decoder_scan;

   localparam int SEL_W = 3;
   localparam int NOUT  = 8;
   localparam int DW_A  = 4;
   localparam int DW_B  = 1;
`ifdef DEC_SCAN_EN
   localparam bit SCAN_ON = 1'b1;
`else
   localparam bit SCAN_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0, en = 1'b0, mode = 1'b0, sel_valid = 1'b0;
   logic [2:0] sel = '0;
   logic       rdy_a, rdy_b, wrap_a, wrap_b;
   logic [7:0] y_a, y_b;
   logic [2:0] idx_a, idx_b;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   decoder_scan #(.SEL_W(SEL_W), .DWELL(DW_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .sel_valid(sel_valid),
      .sel_ready(rdy_a), .y(y_a), .idx(idx_a), .wrap(wrap_a));

   decoder_scan #(.SEL_W(SEL_W), .DWELL(DW_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .sel_valid(sel_valid),
      .sel_ready(rdy_b), .y(y_b), .idx(idx_b), .wrap(wrap_b));

   // Model: st 0=off 1=hold 2=scan; in scan, t counts cycles since entry.
   typedef struct { int st; int code; int t; bit wrap; } mstate_t;
   typedef struct { logic [7:0] y; logic [2:0] idx; logic wrap; logic rdy; } exp_t;

   mstate_t ma, mb;
   exp_t    q_a[$], q_b[$];

   function automatic mstate_t mstep(mstate_t s, int dwell, bit r, bit e, bit m, bit v, int sv);
      mstate_t n = s;
      bit meff = SCAN_ON && m;
      n.wrap = 1'b0;
      if (!r) begin
         n.st = 0; n.code = 0; n.t = 0;
      end else if (!e) begin
         n.st = 0;
      end else if (v && !meff) begin
         n.st = 1; n.code = sv;
      end else if (meff && s.st != 2) begin
         n.st = 2; n.code = 0; n.t = 0;
      end else if (s.st == 2) begin
         if (!meff) n.st = 0;
         else begin
            n.t    = s.t + 1;
            n.code = (n.t / dwell) % NOUT;
            n.wrap = (n.t % (dwell * NOUT)) == 0;
         end
      end
      return n;
   endfunction

   function automatic exp_t expect_of(mstate_t s, bit rdy);
      exp_t x;
      x.y    = (s.st == 0) ? 8'h00 : 8'(1 << s.code);
      x.idx  = 3'(s.code);
      x.wrap = s.wrap;
      x.rdy  = rdy;
      return x;
   endfunction

   task automatic step(bit r, bit e, bit m, bit v, int sv);
      bit rdy;
      @(negedge clk);
      rst_n = r; en = e; mode = m; sel_valid = v; sel = 3'(sv);
      rdy = e && !(SCAN_ON && m);
      ma = mstep(ma, DW_A, r, e, m, v, sv);
      mb = mstep(mb, DW_B, r, e, m, v, sv);
      q_a.push_back(expect_of(ma, rdy));
      q_b.push_back(expect_of(mb, rdy));
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: pops one expectation per clock and compares both instances.
   always @(posedge clk) begin
      exp_t ea, eb;
      #1;
      if (q_a.size() > 0) begin
         ea = q_a.pop_front();
         chk("a_y", 32'(y_a), 32'(ea.y));
         chk("a_idx", 32'(idx_a), 32'(ea.idx));
         chk("a_wrap", 32'(wrap_a), 32'(ea.wrap));
         chk("a_ready", 32'(rdy_a), 32'(ea.rdy));
         chk("a_onehot", 32'($countones(y_a) <= 1), 32'(1));
      end
      if (q_b.size() > 0) begin
         eb = q_b.pop_front();
         chk("b_y", 32'(y_b), 32'(eb.y));
         chk("b_idx", 32'(idx_b), 32'(eb.idx));
         chk("b_wrap", 32'(wrap_b), 32'(eb.wrap));
         chk("b_ready", 32'(rdy_b), 32'(eb.rdy));
      end
   end

   initial begin
      ma = '{0, 0, 0, 1'b0};
      mb = '{0, 0, 0, 1'b0};
      // Reset, load sel=5, hold, then disable.
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 3);
      step(1, 1, 0, 1, 5);
      repeat (3) step(1, 1, 0, 0, 1);
      step(1, 0, 0, 1, 2);
      step(1, 0, 0, 0, 0);
      // Full scan with wrap, then scan exit through a handshake at idx=3.
      step(1, 1, 0, 1, 1);
      repeat (36) step(1, 1, 1, 0, 0);
      repeat (11) step(1, 1, 1, 0, 0);
      step(1, 1, 0, 1, 6);
      step(1, 1, 0, 0, 0);
      // Scan exit without handshake.
      repeat (14) step(1, 1, 1, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      // Reset at idx=7, dwell 3.
      repeat (32) step(1, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      step(1, 1, 0, 1, 2);
      step(1, 1, 1, 1, 2);
      // Randomized phase with sticky mode so scans run long enough to wrap.
      begin
         bit m = 1'b0;
         for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(39) == 0) m = ~m;
            step($urandom_range(249) != 0, $urandom_range(29) != 0, m,
                 $urandom_range(2) == 0, int'($urandom_range(7)));
         end
      end
      repeat (3) @(negedge clk);
      tests++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d/%0d entries left, expected 0", q_a.size(), q_b.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
